// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the two-port memory arbiter: FSM state encoding,
// owner constants and the wait-counter width.
package mem_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUSY = 2'b01,
    RESP = 2'b10
  } state_t;

  localparam logic CORE   = 1'b0;
  localparam logic LOADER = 1'b1;

  localparam int CNT_W = 8;

endpackage

// File: rtl/mem_arbiter_pick.sv
// Two-requester priority picker. ptr is the port granted last time; on a tie
// the other port wins. Holding ptr at LOADER makes the core win every tie.
module mem_arb_pick
  import mem_arbiter_pkg::*;
(
  input  logic req0,
  input  logic req1,
  input  logic ptr,
  output logic grant
);

  // Select the granted port from the two requests and the last-grant pointer
  always_comb begin
    grant = CORE;
    if (req0 && req1) begin
      grant = ~ptr;
    end else if (req1) begin
      grant = LOADER;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Two-port (core / loader) arbiter in front of a single memory port.
// One access at a time: IDLE grants a port and captures its request, BUSY
// holds mem_req until mem_ready (or a wait timeout), RESP pulses done.
// Build option: define MEM_ARB_RR_EN for round-robin tie breaking; otherwise
// the core always wins a tie.
// Handshake: a port holds req until the cycle after its done pulse; the memory
// completes the access in any BUSY cycle where mem_ready is high, and
// mem_rdata is sampled only in that cycle.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              p0_req,
  input  logic              p0_we,
  input  logic [ADDR_W-1:0] p0_addr,
  input  logic [DATA_W-1:0] p0_wdata,
  output logic              p0_done,
  input  logic              p1_req,
  input  logic              p1_we,
  input  logic [ADDR_W-1:0] p1_addr,
  input  logic [DATA_W-1:0] p1_wdata,
  output logic              p1_done,
  output logic [DATA_W-1:0] rdata,
  output logic              core_stall,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ready,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              err,
  output logic [1:0]        dbg_state
);

  localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);

  state_t             state_q, state_d;
  logic               owner_q, owner_d;
  logic               ptr_q, ptr_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               mem_req_q, mem_req_d;
  logic               mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]  mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]  mem_wdata_q, mem_wdata_d;
  logic [DATA_W-1:0]  rdata_q, rdata_d;
  logic               p0_done_q, p0_done_d;
  logic               p1_done_q, p1_done_d;
  logic               err_q, err_d;
  logic               grant;

  mem_arb_pick u_pick (
    .req0  (p0_req),
    .req1  (p1_req),
    .ptr   (ptr_q),
    .grant (grant)
  );

  // Next-state and registered-output computation for the access FSM
  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    ptr_d       = ptr_q;
    cnt_d       = cnt_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    rdata_d     = rdata_q;
    p0_done_d   = 1'b0;
    p1_done_d   = 1'b0;
    err_d       = 1'b0;
    case (state_q)
      IDLE: begin
        if (p0_req || p1_req) begin
          owner_d     = grant;
`ifdef MEM_ARB_RR_EN
          ptr_d       = grant;
`else
          ptr_d       = LOADER;
`endif
          mem_addr_d  = (grant == LOADER) ? p1_addr  : p0_addr;
          mem_wdata_d = (grant == LOADER) ? p1_wdata : p0_wdata;
          mem_we_d    = (grant == LOADER) ? p1_we    : p0_we;
          cnt_d       = '0;
          mem_req_d   = 1'b1;
          state_d     = BUSY;
        end
      end
      BUSY: begin
        if (mem_ready) begin
          rdata_d   = mem_rdata;
          mem_req_d = 1'b0;
          p0_done_d = (owner_q == CORE);
          p1_done_d = (owner_q == LOADER);
          state_d   = RESP;
        end else begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_d == TIMEOUT_C) begin
            err_d     = 1'b1;
            mem_req_d = 1'b0;
            state_d   = IDLE;
          end
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        mem_req_d = 1'b0;
        state_d   = IDLE;
      end
    endcase
  end

  // State and output registers; reset abandons any access in flight
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      owner_q     <= CORE;
      ptr_q       <= LOADER;
      cnt_q       <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      rdata_q     <= '0;
      p0_done_q   <= 1'b0;
      p1_done_q   <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      ptr_q       <= ptr_d;
      cnt_q       <= cnt_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      rdata_q     <= rdata_d;
      p0_done_q   <= p0_done_d;
      p1_done_q   <= p1_done_d;
      err_q       <= err_d;
    end
  end

  assign p0_done    = p0_done_q;
  assign p1_done    = p1_done_q;
  assign rdata      = rdata_q;
  assign mem_req    = mem_req_q;
  assign mem_we     = mem_we_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign err        = err_q;
  assign core_stall = p0_req & ~p0_done_q;
  assign dbg_state  = state_q;

endmodule
